// File: rtl/branch_predictor_btb_pkg.sv
// Shared types and helpers for the branch_predictor_btb slice.
// BRANCH_PREDICTOR_BTB_2BIT_EN selects 2-bit saturating direction counters; default is 1-bit last-outcome.
package branch_predictor_btb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } btb_state_e;

`ifdef BRANCH_PREDICTOR_BTB_2BIT_EN
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_SNT   = 2'b00;
    localparam logic [CNT_W-1:0] CNT_WNT   = 2'b01;
    localparam logic [CNT_W-1:0] CNT_WT    = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ST    = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_WT;
`else
    localparam int CNT_W = 1;
    localparam logic [CNT_W-1:0] CNT_NT    = 1'b0;
    localparam logic [CNT_W-1:0] CNT_T     = 1'b1;
    localparam logic [CNT_W-1:0] CNT_ALLOC = CNT_T;
`endif

    function automatic int entry_count(input int index_w);
        return 1 << index_w;
    endfunction

    // Word-aligned addresses: two low bits drop, then index, then tag.
    function automatic int tag_width(input int index_w, input int addr_w);
        return addr_w - index_w - 2;
    endfunction

    function automatic logic cnt_taken(input logic [CNT_W-1:0] cnt);
        return cnt[CNT_W-1];
    endfunction

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt, input logic taken);
`ifdef BRANCH_PREDICTOR_BTB_2BIT_EN
        case (cnt)
            CNT_SNT: return taken ? CNT_WNT : CNT_SNT;
            CNT_WNT: return taken ? CNT_WT  : CNT_SNT;
            CNT_WT:  return taken ? CNT_ST  : CNT_WNT;
            default: return taken ? CNT_ST  : CNT_WT;
        endcase
`else
        return taken ? CNT_T : (cnt & CNT_NT);
`endif
    endfunction

endpackage

// File: rtl/branch_predictor_btb_array.sv
// Direct-mapped BTB storage: one combinational read port, one training write port, one valid-clear port.
// No per-entry reset; the owner invalidates entries through the clear port.
module btb_array
    import branch_predictor_btb_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int ADDR_W = 32,
    localparam int TAG_W = tag_width(INDEX_W, ADDR_W),
    localparam int ENTRIES = entry_count(INDEX_W)
) (
    input  logic               iCLOCK,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [ADDR_W-1:0]  rd_target,
    output logic [CNT_W-1:0]   rd_cnt,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [ADDR_W-1:0]  wr_target,
    input  logic               wr_taken,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] clr_index
);

    logic              valid_q  [ENTRIES];
    logic [TAG_W-1:0]  tag_q    [ENTRIES];
    logic [ADDR_W-1:0] target_q [ENTRIES];
    logic [CNT_W-1:0]  cnt_q    [ENTRIES];

    logic             wr_hit;
    logic [CNT_W-1:0] wr_cnt_d;

    assign rd_valid  = valid_q[rd_index];
    assign rd_tag    = tag_q[rd_index];
    assign rd_target = target_q[rd_index];
    assign rd_cnt    = cnt_q[rd_index];

    always_comb begin
        wr_hit   = valid_q[wr_index] && (tag_q[wr_index] == wr_tag);
        wr_cnt_d = wr_hit ? cnt_next(cnt_q[wr_index], wr_taken) : CNT_ALLOC;
    end

    // A miss only allocates on a taken outcome; a hit always trains the counter.
    always_ff @(posedge iCLOCK) begin
        if (clr_en) begin
            valid_q[clr_index] <= 1'b0;
        end else if (wr_en && (wr_hit || wr_taken)) begin
            valid_q[wr_index] <= 1'b1;
            cnt_q[wr_index]   <= wr_cnt_d;
            if (wr_taken) begin
                tag_q[wr_index]    <= wr_tag;
                target_q[wr_index] <= wr_target;
            end
        end
    end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with registered lookup and sweep-based invalidation.
// Define BRANCH_PREDICTOR_BTB_2BIT_EN for 2-bit saturating direction counters.
module branch_predictor_btb
    import branch_predictor_btb_pkg::*;
#(
    parameter int INDEX_W = 4,
    parameter int ADDR_W = 32
) (
    input  logic              iCLOCK,
    input  logic              inRESET,
    input  logic              iFLUSH,
    input  logic              iSEARCH_STB,
    input  logic [ADDR_W-1:0] iSEARCH_INST_ADDR,
    input  logic              iSEARCH_LOCK,
    output logic              oSEARCH_VALID,
    output logic              oSEARCH_HIT,
    output logic              oSEARCH_PREDICT_BRANCH,
    output logic [ADDR_W-1:0] oSEARCH_ADDR,
    input  logic              iJUMP_STB,
    input  logic              iJUMP_VALID,
    input  logic [ADDR_W-1:0] iJUMP_ADDR,
    input  logic [ADDR_W-1:0] iJUMP_INST_ADDR,
    output logic              oBUSY
);

    localparam int TAG_W = tag_width(INDEX_W, ADDR_W);

    btb_state_e         state_q, state_d;
    logic [INDEX_W-1:0] ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic               hit_q, hit_d;
    logic               predict_q, predict_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [INDEX_W-1:0] search_index, jump_index;
    logic [TAG_W-1:0]   search_tag, jump_tag;
    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [ADDR_W-1:0]  rd_target;
    logic [CNT_W-1:0]   rd_cnt;
    logic               lookup_hit, train_en, sweep_en;
    logic               unused_low_bits;

    assign search_index    = iSEARCH_INST_ADDR[INDEX_W+1:2];
    assign search_tag      = iSEARCH_INST_ADDR[ADDR_W-1:INDEX_W+2];
    assign jump_index      = iJUMP_INST_ADDR[INDEX_W+1:2];
    assign jump_tag        = iJUMP_INST_ADDR[ADDR_W-1:INDEX_W+2];
    assign unused_low_bits = ^{iSEARCH_INST_ADDR[1:0], iJUMP_INST_ADDR[1:0]};

    btb_array #(
        .INDEX_W (INDEX_W),
        .ADDR_W  (ADDR_W)
    ) u_array (
        .iCLOCK    (iCLOCK),
        .rd_index  (search_index),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .rd_cnt    (rd_cnt),
        .wr_en     (train_en),
        .wr_index  (jump_index),
        .wr_tag    (jump_tag),
        .wr_target (iJUMP_ADDR),
        .wr_taken  (iJUMP_VALID),
        .clr_en    (sweep_en),
        .clr_index (ptr_q)
    );

    // Storage contents are meaningless until the sweep finishes, so INIT forces a miss.
    always_comb begin
        sweep_en   = (state_q == ST_INIT);
        lookup_hit = (state_q == ST_IDLE) && rd_valid && (rd_tag == search_tag);
        train_en   = (state_q == ST_IDLE) && iJUMP_STB && !iFLUSH;

        state_d   = state_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        hit_d     = hit_q;
        predict_d = predict_q;
        addr_d    = addr_q;

        if (iFLUSH) begin
            state_d = ST_INIT;
            ptr_d   = '0;
        end else if (state_q == ST_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) begin
                state_d = ST_IDLE;
            end
        end

        if (iFLUSH) begin
            valid_d = 1'b0;
        end else if (!iSEARCH_LOCK) begin
            valid_d   = iSEARCH_STB;
            hit_d     = lookup_hit;
            predict_d = lookup_hit && cnt_taken(rd_cnt);
            addr_d    = lookup_hit ? rd_target : '0;
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q   <= ST_INIT;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            hit_q     <= 1'b0;
            predict_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            hit_q     <= hit_d;
            predict_q <= predict_d;
            addr_q    <= addr_d;
        end
    end

    assign oSEARCH_VALID          = valid_q;
    assign oSEARCH_HIT            = hit_q;
    assign oSEARCH_PREDICT_BRANCH = predict_q;
    assign oSEARCH_ADDR           = addr_q;
    assign oBUSY                  = (state_q == ST_INIT);

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Self-checking bench for branch_predictor_btb: directed scenarios plus randomized traffic
// against a table-level model of the BTB (entries, tags, targets, direction counters).
module tb_branch_predictor_btb;

    localparam int INDEX_W = 4;
    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;

    logic              iCLOCK = 1'b0;
    logic              inRESET;
    logic              iFLUSH;
    logic              iSEARCH_STB;
    logic [ADDR_W-1:0] iSEARCH_INST_ADDR;
    logic              iSEARCH_LOCK;
    logic              oSEARCH_VALID;
    logic              oSEARCH_HIT;
    logic              oSEARCH_PREDICT_BRANCH;
    logic [ADDR_W-1:0] oSEARCH_ADDR;
    logic              iJUMP_STB;
    logic              iJUMP_VALID;
    logic [ADDR_W-1:0] iJUMP_ADDR;
    logic [ADDR_W-1:0] iJUMP_INST_ADDR;
    logic              oBUSY;

    branch_predictor_btb #(
        .INDEX_W (INDEX_W),
        .ADDR_W  (ADDR_W)
    ) dut (
        .iCLOCK                 (iCLOCK),
        .inRESET                (inRESET),
        .iFLUSH                 (iFLUSH),
        .iSEARCH_STB            (iSEARCH_STB),
        .iSEARCH_INST_ADDR      (iSEARCH_INST_ADDR),
        .iSEARCH_LOCK           (iSEARCH_LOCK),
        .oSEARCH_VALID          (oSEARCH_VALID),
        .oSEARCH_HIT            (oSEARCH_HIT),
        .oSEARCH_PREDICT_BRANCH (oSEARCH_PREDICT_BRANCH),
        .oSEARCH_ADDR           (oSEARCH_ADDR),
        .iJUMP_STB              (iJUMP_STB),
        .iJUMP_VALID            (iJUMP_VALID),
        .iJUMP_ADDR             (iJUMP_ADDR),
        .iJUMP_INST_ADDR        (iJUMP_INST_ADDR),
        .oBUSY                  (oBUSY)
    );

    always #5 iCLOCK = ~iCLOCK;

    int checks = 0;
    int errors = 0;

    // Reference model: a table of entries plus a countdown of remaining busy cycles.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [31:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int          m_busy_left;
    logic        e_valid, e_hit, e_pred;
    logic [31:0] e_addr;

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[5:2]);
    endfunction

    function automatic int unsigned tag_of(input logic [31:0] a);
        return a >> 6;
    endfunction

`ifdef BRANCH_PREDICTOR_BTB_2BIT_EN
    function automatic bit taken_of(input int c);
        return c >= 2;
    endfunction
    function automatic int next_cnt(input int c, input bit t);
        if (t) return (c >= 3) ? 3 : c + 1;
        return (c <= 0) ? 0 : c - 1;
    endfunction
    localparam int ALLOC_CNT = 2;
`else
    function automatic bit taken_of(input int c);
        return c == 1;
    endfunction
    function automatic int next_cnt(input int c, input bit t);
        return (t || (c < 0)) ? 1 : 0;
    endfunction
    localparam int ALLOC_CNT = 1;
`endif

    task automatic model_clear();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_busy_left = ENTRIES;
    endtask

    // Advance model and DUT by one clock using the currently driven inputs.
    task automatic tick();
        int  si, ji;
        bit  hit;
        if (iFLUSH) begin
            e_valid = 1'b0;
            model_clear();
        end else begin
            if (!iSEARCH_LOCK) begin
                si      = idx_of(iSEARCH_INST_ADDR);
                hit     = (m_busy_left == 0) && m_valid[si] && (m_tag[si] == tag_of(iSEARCH_INST_ADDR));
                e_valid = iSEARCH_STB;
                e_hit   = hit;
                e_pred  = hit && taken_of(m_cnt[si]);
                e_addr  = hit ? m_target[si] : 32'h0;
            end
            if ((m_busy_left == 0) && iJUMP_STB) begin
                ji = idx_of(iJUMP_INST_ADDR);
                if (m_valid[ji] && (m_tag[ji] == tag_of(iJUMP_INST_ADDR))) begin
                    m_cnt[ji] = next_cnt(m_cnt[ji], iJUMP_VALID);
                    if (iJUMP_VALID) m_target[ji] = iJUMP_ADDR;
                end else if (iJUMP_VALID) begin
                    m_valid[ji]  = 1'b1;
                    m_tag[ji]    = tag_of(iJUMP_INST_ADDR);
                    m_target[ji] = iJUMP_ADDR;
                    m_cnt[ji]    = ALLOC_CNT;
                end
            end
            if (m_busy_left > 0) m_busy_left--;
        end
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic set_search(input logic stb, input logic [31:0] a, input logic lock);
        iSEARCH_STB       = stb;
        iSEARCH_INST_ADDR = a;
        iSEARCH_LOCK      = lock;
    endtask

    task automatic set_jump(input logic stb, input logic taken, input logic [31:0] inst, input logic [31:0] tgt);
        iJUMP_STB       = stb;
        iJUMP_VALID     = taken;
        iJUMP_INST_ADDR = inst;
        iJUMP_ADDR      = tgt;
    endtask

    task automatic test_reset();
        int n;
        inRESET = 1'b0;
        iFLUSH  = 1'b0;
        set_search(1'b0, 32'h0, 1'b0);
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
        model_clear();
        e_valid = 1'b0; e_hit = 1'b0; e_pred = 1'b0; e_addr = 32'h0;
        #22;
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR, oBUSY} !== {3'b000, 32'h0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_values: got v%0b h%0b p%0b a%h busy%0b expected v0 h0 p0 a0 busy1",
                     oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR, oBUSY);
        end
        @(posedge iCLOCK);
        #1;
        inRESET = 1'b1;
        n = 0;
        while (oBUSY === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("[TB] FAIL reset_sweep_len: got %0d busy cycles expected 16", n);
        end
        set_search(1'b1, 32'h100, 1'b0);
        tick();
        set_search(1'b0, 32'h0, 1'b0);
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {3'b100, 32'h0}) begin
            errors++;
            $display("[TB] FAIL reset_first_search: got v%0b h%0b p%0b a%h expected v1 h0 p0 a0",
                     oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
        end
    endtask

    task automatic test_train_basic();
        set_jump(1'b1, 1'b1, 32'h1004, 32'h2000);
        tick();
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
        set_search(1'b1, 32'h1004, 1'b0);
        tick();
        set_search(1'b0, 32'h0, 1'b0);
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {3'b111, 32'h2000}) begin
            errors++;
            $display("[TB] FAIL alloc_hit: got v%0b h%0b p%0b a%h expected v1 h1 p1 a2000",
                     oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
        end
    endtask

    task automatic test_counter();
        for (int i = 0; i < 2; i++) begin
            set_jump(1'b1, 1'b0, 32'h1004, 32'hDEAD_0000);
            tick();
        end
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
        set_search(1'b1, 32'h1004, 1'b0);
        tick();
        checks++;
        if ({oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {2'b10, 32'h2000}) begin
            errors++;
            $display("[TB] FAIL counter_not_taken: got h%0b p%0b a%h expected h1 p0 a2000",
                     oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
        end
        set_search(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            set_jump(1'b1, 1'b1, 32'h1004, 32'h2000);
            tick();
        end
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
        set_search(1'b1, 32'h1004, 1'b0);
        tick();
        set_search(1'b0, 32'h0, 1'b0);
        checks++;
        if ({oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {2'b11, 32'h2000}) begin
            errors++;
            $display("[TB] FAIL counter_taken: got h%0b p%0b a%h expected h1 p1 a2000",
                     oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
        end
    endtask

    task automatic test_alias();
        set_search(1'b1, 32'h1044, 1'b0);
        tick();
        checks++;
        if ({oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {2'b00, 32'h0}) begin
            errors++;
            $display("[TB] FAIL alias_miss: got h%0b p%0b a%h expected h0 p0 a0",
                     oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
        end
        set_search(1'b0, 32'h0, 1'b0);
        set_jump(1'b1, 1'b1, 32'h1044, 32'h3000);
        tick();
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
        set_search(1'b1, 32'h1044, 1'b0);
        tick();
        checks++;
        if ({oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {2'b11, 32'h3000}) begin
            errors++;
            $display("[TB] FAIL alias_alloc: got h%0b p%0b a%h expected h1 p1 a3000",
                     oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
        end
        set_search(1'b1, 32'h1004, 1'b0);
        tick();
        set_search(1'b0, 32'h0, 1'b0);
        checks++;
        if ({oSEARCH_HIT, oSEARCH_ADDR} !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL alias_evicted: got h%0b a%h expected h0 a0", oSEARCH_HIT, oSEARCH_ADDR);
        end
    endtask

    task automatic test_back_to_back();
        set_search(1'b1, 32'h1004, 1'b0);
        set_jump(1'b1, 1'b1, 32'h1004, 32'h2000);
        tick();
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_ADDR} !== {2'b10, 32'h0}) begin
            errors++;
            $display("[TB] FAIL read_before_write: got v%0b h%0b a%h expected v1 h0 a0",
                     oSEARCH_VALID, oSEARCH_HIT, oSEARCH_ADDR);
        end
        tick();
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {3'b111, 32'h2000}) begin
            errors++;
            $display("[TB] FAIL update_visible_next: got v%0b h%0b p%0b a%h expected v1 h1 p1 a2000",
                     oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
        end
    endtask

    task automatic test_lock();
        logic [31:0] addrs [3];
        addrs[0] = 32'h100;
        addrs[1] = 32'h1044;
        addrs[2] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            set_search(1'b1, addrs[i], 1'b1);
            tick();
            checks++;
            if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR} !== {3'b111, 32'h2000}) begin
                errors++;
                $display("[TB] FAIL lock_hold_%0d: got v%0b h%0b p%0b a%h expected v1 h1 p1 a2000", i,
                         oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR);
            end
        end
        set_search(1'b0, 32'h100, 1'b0);
        tick();
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL lock_strobe_dropped: got v%0b h%0b expected v0 h0", oSEARCH_VALID, oSEARCH_HIT);
        end
    endtask

    task automatic test_flush();
        int n;
        iFLUSH = 1'b1;
        set_search(1'b1, 32'h1004, 1'b0);
        tick();
        iFLUSH = 1'b0;
        set_search(1'b0, 32'h0, 1'b0);
        checks++;
        if ({oSEARCH_VALID, oBUSY} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL flush_clears_valid: got v%0b busy%0b expected v0 busy1", oSEARCH_VALID, oBUSY);
        end
        for (int i = 0; i < 5; i++) tick();
        iFLUSH = 1'b1;
        set_jump(1'b1, 1'b1, 32'h1004, 32'h5000);
        tick();
        iFLUSH = 1'b0;
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
        n = 1;
        while (oBUSY === 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n != 17) begin
            errors++;
            $display("[TB] FAIL flush_restart_len: got %0d busy cycles expected 16", n - 1);
        end
        set_search(1'b1, 32'h1004, 1'b0);
        tick();
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_ADDR} !== {2'b10, 32'h0}) begin
            errors++;
            $display("[TB] FAIL flush_miss_1004: got v%0b h%0b a%h expected v1 h0 a0",
                     oSEARCH_VALID, oSEARCH_HIT, oSEARCH_ADDR);
        end
        set_search(1'b1, 32'h1044, 1'b0);
        tick();
        set_search(1'b0, 32'h0, 1'b0);
        checks++;
        if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_ADDR} !== {2'b10, 32'h0}) begin
            errors++;
            $display("[TB] FAIL flush_miss_1044: got v%0b h%0b a%h expected v1 h0 a0",
                     oSEARCH_VALID, oSEARCH_HIT, oSEARCH_ADDR);
        end
    endtask

    // Small index/tag pool so random traffic produces hits, aliases and counter saturation.
    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 500; i++) begin
            a = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
            set_search($urandom_range(0, 9) < 7, a, $urandom_range(0, 99) < 15);
            a = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 3)) << 2);
            set_jump($urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6, a, $urandom & 32'hFFFF_FFFC);
            iFLUSH = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if ({oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR, oBUSY} !==
                {e_valid, e_hit, e_pred, e_addr, (m_busy_left > 0)}) begin
                errors++;
                $display("[TB] FAIL random_%0d: got v%0b h%0b p%0b a%h busy%0b expected v%0b h%0b p%0b a%h busy%0b",
                         i, oSEARCH_VALID, oSEARCH_HIT, oSEARCH_PREDICT_BRANCH, oSEARCH_ADDR, oBUSY,
                         e_valid, e_hit, e_pred, e_addr, (m_busy_left > 0));
            end
        end
        iFLUSH = 1'b0;
        set_search(1'b0, 32'h0, 1'b0);
        set_jump(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_train_basic();
        test_counter();
        test_alias();
        test_back_to_back();
        test_lock();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
